// File: rtl/grng_out_stage.sv
// Output stage of the ICDF Gaussian generator: re-attaches the delayed sign with
// saturating negation, buffers results in an FWFT FIFO and drives the pipeline enable.
module grng_out_stage #(
  parameter int LAT   = 3,
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       sign_in,
  input  logic signed [DW-1:0]       ma21_in,
  output logic                       en_pipe,
  output logic signed [DW-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);
  localparam logic [LW-1:0] Margin = LW'(LAT + 1);
  localparam logic [DW-1:0] MinVal = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MaxVal = {1'b0, {(DW-1){1'b1}}};

  logic [LAT-1:0] tagValid_q, tagValid_d;
  logic [LAT-1:0] tagSign_q, tagSign_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wrPtr_q, wrPtr_d;
  logic [AW-1:0]  rdPtr_q, rdPtr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           enPipe_q, enPipe_d;
  logic           overflow_q, overflow_d;
  logic           tapValid, tapSign, full, push, pop;
  logic [DW-1:0]  result;

  // The tag line mirrors the multiply-add pipeline, including its flush when disabled.
  always_comb begin
    tagValid_d = '0;
    tagSign_d  = '0;
    if (enPipe_q) begin
      tagValid_d = (tagValid_q << 1) | LAT'(in_valid);
      tagSign_d  = (tagSign_q << 1) | LAT'(sign_in);
    end
  end

  assign tapValid = tagValid_q[LAT-1];
  assign tapSign  = tagSign_q[LAT-1];

  always_comb begin
    result = ma21_in;
    if (tapSign) begin
      result = (ma21_in == MinVal) ? MaxVal : -ma21_in;
    end
  end

  assign out_valid = (level_q != '0);
  assign full      = (level_q == DepthL);
  assign pop       = out_valid & out_ready;
  assign push      = tapValid & (~full | pop);

  always_comb begin
    overflow_d = overflow_q | (tapValid & full & ~pop);
    wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Keep enough free slots to absorb everything still inside the multiply-add pipeline.
    enPipe_d = ((DepthL - level_d) >= Margin);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tagValid_q <= '0;
      tagSign_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      enPipe_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      tagValid_q <= tagValid_d;
      tagSign_q  <= tagSign_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      enPipe_q   <= enPipe_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= result;
    end
  end

  assign out_data   = out_valid ? mem_q[rdPtr_q] : '0;
  assign en_pipe    = enPipe_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_grng_out_stage.sv
// Directed bench for grng_out_stage: sign handling, latency, backpressure,
// simultaneous push/pop and mid-operation reset with hand-computed expectations.
module tb_grng_out_stage;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        signIn;
  logic [15:0] maIn;
  logic        enPipe;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;
  logic [3:0]  fifoLevel;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int maxLevel;
  logic sawOverflow;
  logic sawValid;

  grng_out_stage #(.LAT(3), .DEPTH(8), .DW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .sign_in    (signIn),
    .ma21_in    (maIn),
    .en_pipe    (enPipe),
    .out_data   (outData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .fifo_level (fifoLevel),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs; outputs are stable for checking on return.
  task automatic applyStimulus(input logic iv, input logic sg, input logic [15:0] ma, input logic rdy);
    inValid  = iv;
    signIn   = sg;
    maIn     = ma;
    outReady = rdy;
    @(posedge clk);
    #1;
  endtask

  // One sample through the pipe; multiply-add result appears three cycles after acceptance.
  task automatic sendOne(input logic sg, input logic [15:0] ma, input logic rdyAtTap);
    applyStimulus(1'b1, sg, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("no_early_valid", {31'd0, outValid}, {31'd0, rdyAtTap});
    applyStimulus(1'b0, 1'b0, ma, rdyAtTap);
  endtask

  initial begin
    rst = 1'b0;
    inValid = 1'b0;
    signIn = 1'b0;
    maIn = 16'h0000;
    outReady = 1'b0;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    end
    checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, outData}, 32'd0);
    checkOutput("rst_level", {28'd0, fifoLevel}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_en_pipe", {31'd0, enPipe}, 32'd0);

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("release_en_pipe", {31'd0, enPipe}, 32'd1);
    checkOutput("release_level", {28'd0, fifoLevel}, 32'd0);

    sendOne(1'b0, 16'h1234, 1'b0);
    checkOutput("pos_valid", {31'd0, outValid}, 32'd1);
    checkOutput("pos_data", {16'd0, outData}, 32'h1234);
    checkOutput("pos_level", {28'd0, fifoLevel}, 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("pos_pop_valid", {31'd0, outValid}, 32'd0);
    checkOutput("pos_pop_level", {28'd0, fifoLevel}, 32'd0);

    sendOne(1'b1, 16'h1234, 1'b0);
    checkOutput("neg_data", {16'd0, outData}, 32'h0000EDCC);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    sendOne(1'b1, 16'h8000, 1'b0);
    checkOutput("sat_data", {16'd0, outData}, 32'h00007FFF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    sendOne(1'b1, 16'h0000, 1'b0);
    checkOutput("neg_zero_valid", {31'd0, outValid}, 32'd1);
    checkOutput("neg_zero_data", {16'd0, outData}, 32'h0000);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    sendOne(1'b1, 16'h0001, 1'b0);
    checkOutput("neg_one_data", {16'd0, outData}, 32'h0000FFFF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    sendOne(1'b0, 16'h7FFF, 1'b0);
    checkOutput("pos_max_data", {16'd0, outData}, 32'h00007FFF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    // Simultaneous push and pop keeps the level while the head advances.
    sendOne(1'b0, 16'h0101, 1'b0);
    sendOne(1'b0, 16'h0202, 1'b1);
    checkOutput("pushpop_level", {28'd0, fifoLevel}, 32'd1);
    checkOutput("pushpop_head", {16'd0, outData}, 32'h0202);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("pushpop_empty", {31'd0, outValid}, 32'd0);

    // Continuous input under backpressure: sample accepted at cycle k carries value k+1.
    maxLevel = 0;
    sawOverflow = 1'b0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b0, (k >= 3) ? 16'(k - 2) : 16'h0000, 1'b0);
      if (int'(fifoLevel) > maxLevel) maxLevel = int'(fifoLevel);
      if (overflow) sawOverflow = 1'b1;
      if (k == 6) checkOutput("bp_en_hold", {31'd0, enPipe}, 32'd1);
      if (k == 7) checkOutput("bp_en_drop", {31'd0, enPipe}, 32'd0);
    end
    checkOutput("bp_level", {28'd0, fifoLevel}, 32'd6);
    checkOutput("bp_max_level", 32'(maxLevel), 32'd6);
    checkOutput("bp_overflow", {31'd0, sawOverflow}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("drain_valid", {31'd0, outValid}, 32'd1);
      checkOutput("drain_data", {16'd0, outData}, 32'(i + 1));
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    end
    checkOutput("drain_empty", {31'd0, outValid}, 32'd0);
    checkOutput("drain_en_back", {31'd0, enPipe}, 32'd1);

    // Fill to five with two samples still in flight, then reset for one cycle.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(k <= 6, 1'b0, 16'h0500 + 16'(k), 1'b0);
    end
    checkOutput("mid_level_before", {28'd0, fifoLevel}, 32'd5);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0600, 1'b0);
    checkOutput("mid_rst_valid", {31'd0, outValid}, 32'd0);
    checkOutput("mid_rst_level", {28'd0, fifoLevel}, 32'd0);
    checkOutput("mid_rst_en", {31'd0, enPipe}, 32'd0);
    rst = 1'b1;
    sawValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0700, 1'b1);
      if (outValid) sawValid = 1'b1;
    end
    checkOutput("mid_no_ghost", {31'd0, sawValid}, 32'd0);
    checkOutput("mid_en_after", {31'd0, enPipe}, 32'd1);
    checkOutput("final_overflow", {31'd0, overflow}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/grng_out_stage.md
Name: grng_out_stage

Overview:
- Final output stage of the ICDF Gaussian generator. Sits directly downstream of the 21-bit multiply-add stage and consumes its 16-bit truncated result.
- Re-attaches the sign bit of the uniform sample, which is delay-matched to the multiply-add latency, and applies it with saturating negation.
- Buffers results in a first-word-fall-through (FWFT) FIFO behind a valid/ready handshake.
- Generates the pipeline enable (en_pipe). Backpressure can never overflow the FIFO.

Parameters:
- LAT, 3, cycles from sample presented at multiply-add inputs to its result on ma21_in.
- DEPTH, 8, FIFO entries. Power of 2; DEPTH >= LAT+2.
- DW, 16, sample width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- in_valid  in  1  a new sample is presented to the multiply-add stage this cycle.
- sign_in  in  1  sign bit of that sample (1 = negative).
- ma21_in  in  DW  signed result from the multiply-add stage.
- en_pipe  out  1  enable to the multiply-add stage. Low flushes its pipeline.
- out_data  out  DW  signed Gaussian sample (FIFO head).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky error flag: a write was attempted while the FIFO was full.

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: out_data=0, out_valid=0, fifo_level=0, overflow=0, en_pipe=0.
  - Internal state: delay line cleared; FIFO pointers zeroed.
  - Reset has priority over every other event, including a reset asserted mid-transfer. FIFO contents and in-flight samples are discarded.
- Delay line:
  - LAT stages, each carrying {valid, sign}.
  - en_pipe=1: shifts each cycle; stage 0 loads {in_valid, sign_in}.
  - en_pipe=0: all stages clear, mirroring the flush in the multiply-add stage. in_valid is ignored while en_pipe=0.
- Sign application at the delay-line tap (valid=1):
  - sign=0: result = ma21_in.
  - sign=1: result = -ma21_in in two's complement.
  - Saturation: -(-32768) -> +32767 (0x8000 -> 0x7FFF).
- FIFO write: the result is written on the same edge as the tap becomes valid.
  - Full with no simultaneous pop: write dropped, overflow set. Overflow stays set until reset.
- FIFO read:
  - out_valid = (level != 0); out_data = head entry.
  - A pop occurs when out_valid & out_ready.
- Simultaneous events:
  - Push and pop with FIFO full: both occur; level unchanged; no overflow.
  - Push into an empty FIFO: the entry becomes visible the next cycle. There is no same-cycle bypass.
- Occupancy: fifo_level updates +1 on push, -1 on pop, unchanged on both. Pointers wrap modulo DEPTH.
- Latency: a sample accepted at cycle t (in_valid=1, en_pipe=1) is written at the end of cycle t+LAT and appears with out_valid at t+LAT+1.
- en_pipe rule:
  - Registered. en_pipe(t+1) = 1 iff (DEPTH - fifo_level after cycle t's push/pop) >= LAT+1.
  - Consequence: the LAT-sample in-flight margin guarantees overflow is never set in legal operation.
  - Samples in flight when en_pipe falls are flushed and lost. This is acceptable for RNG output.
- Ordering: output order equals acceptance order of surviving samples.

Test Plan:
- Reset: hold rst=0 for 5 cycles with random inputs -> all outputs 0. Release rst -> en_pipe=1 on the following cycle; fifo_level=0.
- Single positive sample: in_valid=1, sign_in=0 at cycle t; ma21_in=0x1234 at t+3 -> out_valid=1, out_data=0x1234 at t+4. Pulse out_ready -> out_valid=0, fifo_level=0.
- Negation and saturation: sign=1 with ma21_in=0x1234 -> out_data=0xEDCC. sign=1 with 0x8000 -> 0x7FFF. sign=1 with 0x0000 -> 0x0000.
- Backpressure: out_ready=0, in_valid=1 continuously with ma21_in=1,2,3,... -> en_pipe drops once free slots <4; fifo_level never exceeds 8; overflow stays 0. Then out_ready=1 -> entries drain in strictly increasing order, with no duplicates, and the values flushed at en_pipe fall are absent.
- Full push/pop: FIFO at 8 and out_ready=1 on the same edge as a tap write -> level stays 8; overflow 0; head advances by one.
- Mid-operation reset: FIFO at 5 with 2 samples in flight; assert rst=0 for 1 cycle -> out_valid=0, fifo_level=0. No in-flight sample is ever output afterward.
